// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: one synchronous word-addressed RAM shared by N_PORTS requesters.
//
// A round-robin arbiter picks one requesting port at a time. The granted access
// spends WAIT_STATES cycles in BUSY and then completes in a single DONE cycle.
// A requester stalls on rsp_miss until its DONE cycle arrives.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous, active-low reset
//   req_en     per-port request valid; held high until that port's miss drops
//   req_rw     per-port direction, 1 = write, 0 = read
//   req_addr   flattened word addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  flattened write data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_rdata  flattened registered read data, one word per port
//   rsp_miss   per-port stall, combinational
//   rsp_err    per-port out-of-range pulse, registered
//              (present only when UMC_BOUNDS_CHECK_EN is defined)
//
// Optional feature macro: UMC_BOUNDS_CHECK_EN
//   Defined:   an access whose address has any bit set above DEPTH_LOG2 still
//              completes, but it writes nothing, returns 0 and pulses rsp_err.
//   Undefined: the upper address bits are ignored, so addresses wrap onto the RAM.
//
// RAM contents are not cleared by reset.

module unified_mem_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [N_PORTS-1:0]            req_en,
  input  logic [N_PORTS-1:0]            req_rw,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [N_PORTS*DATA_WIDTH-1:0] rsp_rdata,
`ifdef UMC_BOUNDS_CHECK_EN
  output logic [N_PORTS-1:0]            rsp_err,
`endif
  output logic [N_PORTS-1:0]            rsp_miss
);

  localparam int unsigned GrantW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CntW   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned Depth  = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                               state_q, state_d;
  logic [GrantW-1:0]                    grant_q, grant_d;
  logic [GrantW-1:0]                    last_grant_q, last_grant_d;
  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0]                mem [Depth];
  logic                                 mem_we;

  // ---------------------------------------------------------------------------
  // Granted-port request fields
  // ---------------------------------------------------------------------------
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   addr_v;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   wdata_v;
  logic [ADDR_WIDTH-1:0]                sel_addr;
  logic [DATA_WIDTH-1:0]                sel_wdata;
  logic                                 sel_rw;
  logic                                 sel_en;
  logic [DEPTH_LOG2-1:0]                mem_idx;
  logic                                 addr_oob;

  assign addr_v    = req_addr;
  assign wdata_v   = req_wdata;
  assign sel_addr  = addr_v[grant_q];
  assign sel_wdata = wdata_v[grant_q];
  assign sel_rw    = req_rw[grant_q];
  assign sel_en    = req_en[grant_q];
  assign mem_idx   = sel_addr[DEPTH_LOG2-1:0];

  // The upper address bits only matter when the bounds check is built in.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(sel_addr >> DEPTH_LOG2);

`ifdef UMC_BOUNDS_CHECK_EN
  logic [N_PORTS-1:0] err_q, err_d;
  assign addr_oob = |(sel_addr >> DEPTH_LOG2);
  assign rsp_err  = err_q;
`else
  assign addr_oob = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first requesting port after last_grant, wrapping around
  // ---------------------------------------------------------------------------
  logic              rr_found;
  logic [GrantW-1:0] rr_idx;
  logic [GrantW-1:0] cand;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      cand = GrantW'((32'(last_grant_q) + k) % N_PORTS);
      if (!rr_found && req_en[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    mem_we       = 1'b0;
`ifdef UMC_BOUNDS_CHECK_EN
    err_d        = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_idx;
          cnt_d   = CntW'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? StDone : StBusy;
        end
      end

      StBusy: begin
        if (!sel_en) begin
          // Requester gave up: drop the access without touching RAM or rdata.
          state_d = StIdle;
        end else begin
          if (cnt_q <= CntW'(1)) begin
            state_d = StDone;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end

      StDone: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
        if (addr_oob) begin
          rdata_d[grant_q] = '0;
`ifdef UMC_BOUNDS_CHECK_EN
          err_d[grant_q]   = 1'b1;
`endif
        end else if (sel_rw) begin
          mem_we = 1'b1;
        end else begin
          rdata_d[grant_q] = mem[mem_idx];
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GrantW'(N_PORTS - 1);
      cnt_q        <= '0;
      rdata_q      <= '0;
`ifdef UMC_BOUNDS_CHECK_EN
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
`ifdef UMC_BOUNDS_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  // RAM write port. A reset arriving in the DONE cycle cancels the write.
  always_ff @(posedge Clk) begin
    if (Rst && mem_we) begin
      mem[mem_idx] <= sel_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_rdata = rdata_q;

  always_comb begin
    rsp_miss = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      rsp_miss[i] = req_en[i] & ~((state_q == StDone) & (grant_q == GrantW'(i)));
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Self-checking bench for unified_mem_ctrl: directed scenarios followed by random
// traffic. The reference model works at transaction level, using grant times,
// completion stamps and an associative-array memory.
module tb_unified_mem_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DL    = 10;
  localparam int unsigned NP    = 2;
  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 1 << DL;

`ifdef UMC_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic [NP-1:0]    req_en = '0;
  logic [NP-1:0]    req_rw = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic [NP*DW-1:0] rsp_rdata;
  logic [NP-1:0]    rsp_miss;
`ifdef UMC_BOUNDS_CHECK_EN
  logic [NP-1:0]    rsp_err;
`endif

  unified_mem_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL),
    .N_PORTS    (NP),
    .WAIT_STATES(WS)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .req_en   (req_en),
    .req_rw   (req_rw),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata),
`ifdef UMC_BOUNDS_CHECK_EN
    .rsp_err  (rsp_err),
`endif
    .rsp_miss (rsp_miss)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester state (stimulus side)
  bit   [NP-1:0] act;
  bit   [NP-1:0] abort_req;
  logic          r_rw    [NP];
  logic [AW-1:0] r_addr  [NP];
  logic [DW-1:0] r_wdata [NP];
  bit            rand_mode  = 1'b0;
  bit            rand_abort = 1'b0;
  int unsigned   req_pct    = 0;
  bit            rst_now    = 1'b0;

  // Reference model
  int            cyc = 0;
  int            cur = -1;
  int            done_at = 0;
  int            last_g = NP - 1;
  logic [DW-1:0] mem_m [int unsigned];
  logic [DW-1:0] exp_rd [NP];
  bit            rd_known [NP];
  bit            exp_err [NP];

  // Observations
  int            miss_hi [NP];
  int            err_hi  [NP];
  int            waited  [NP];
  int            done_q[$];
  int            done_cyc[$];

  task automatic new_req(input int p);
    act[p]     = 1'b1;
    r_rw[p]    = 1'($urandom_range(0, 1));
    r_addr[p]  = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) r_addr[p] = r_addr[p] | (AW'($urandom_range(1, 7)) << DL);
    r_wdata[p] = DW'($urandom);
  endtask

  task automatic cycle();
    int  p;
    bit  em;
    bit  oob;
    int unsigned idx;
    bit  err_next [NP];
    @(negedge Clk);
    Rst = !rst_now;
    for (int i = 0; i < NP; i++) begin
      if (rand_mode && !act[i] && ($urandom_range(1, 100) <= req_pct)) new_req(i);
      if (act[i] && cur == i && cyc < done_at &&
          (abort_req[i] || (rand_abort && $urandom_range(0, 15) == 0))) begin
        act[i]       = 1'b0;
        abort_req[i] = 1'b0;
      end
      req_en[i]               = act[i];
      req_rw[i]               = r_rw[i];
      req_addr[i*AW +: AW]    = r_addr[i];
      req_wdata[i*DW +: DW]   = r_wdata[i];
      err_next[i]             = 1'b0;
    end
    #1;
    // An idle controller grants the next requester in round-robin order.
    if (cur < 0) begin
      for (int k = 1; k <= NP; k++) begin
        p = (last_g + k) % NP;
        if (req_en[p]) begin
          cur     = p;
          done_at = cyc + WS + 1;
          break;
        end
      end
    end
    if (cur >= 0 && cyc < done_at && !req_en[cur]) cur = -1;
    if (!rst_now) begin
      for (int i = 0; i < NP; i++) begin
        em = req_en[i] && !(cur == i && cyc == done_at);
        check_eq("miss", 64'(rsp_miss[i]), 64'(em));
        if (rd_known[i]) check_eq("rdata", 64'(rsp_rdata[i*DW +: DW]), 64'(exp_rd[i]));
`ifdef UMC_BOUNDS_CHECK_EN
        check_eq("err", 64'(rsp_err[i]), 64'(exp_err[i]));
        if (rsp_err[i]) err_hi[i]++;
`endif
        if (rsp_miss[i]) miss_hi[i]++;
        if (req_en[i] && !rsp_miss[i]) begin
          done_q.push_back(i);
          done_cyc.push_back(cyc);
          for (int j = 0; j < NP; j++) if (j != i && req_en[j]) waited[j]++;
          check_eq("fair_wait", 64'(waited[i] <= NP - 1), 64'd1);
          waited[i] = 0;
        end
        if (!req_en[i]) waited[i] = 0;
      end
    end
    if (rst_now) begin
      cur    = -1;
      last_g = NP - 1;
      act    = '0;
      for (int i = 0; i < NP; i++) begin
        exp_rd[i]   = '0;
        rd_known[i] = 1'b1;
        waited[i]   = 0;
      end
    end else if (cur >= 0 && cyc == done_at) begin
      idx = r_addr[cur] % DEPTH;
      oob = BoundsEn && ((r_addr[cur] >> DL) != 0);
      if (oob) begin
        exp_rd[cur]   = '0;
        rd_known[cur] = 1'b1;
        err_next[cur] = 1'b1;
      end else if (r_rw[cur]) begin
        mem_m[idx] = r_wdata[cur];
      end else if (mem_m.exists(idx)) begin
        exp_rd[cur]   = mem_m[idx];
        rd_known[cur] = 1'b1;
      end else begin
        rd_known[cur] = 1'b0;
      end
      last_g   = cur;
      act[cur] = 1'b0;
      cur      = -1;
    end
    for (int i = 0; i < NP; i++) exp_err[i] = err_next[i];
    cyc++;
  endtask

  task automatic issue(input int p, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    act[p]     = 1'b1;
    r_rw[p]    = rw;
    r_addr[p]  = a;
    r_wdata[p] = d;
  endtask

  task automatic drain();
    int n = 0;
    while ((act != '0 || cur >= 0) && n < 60) begin
      cycle();
      n++;
    end
    check_eq("drain_in_time", 64'(n < 60), 64'd1);
    cycle();
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rsp_rdata[p*DW +: DW];
  endfunction

  initial begin
    for (int i = 0; i < NP; i++) begin
      r_rw[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
      exp_rd[i] = '0; rd_known[i] = 1'b0; exp_err[i] = 1'b0;
      miss_hi[i] = 0; err_hi[i] = 0; waited[i] = 0;
    end
    act = '0; abort_req = '0;

    // Reset, then idle cycle with zeroed read data
    rst_now = 1'b1; cycle(); cycle(); rst_now = 1'b0;
    cycle();
    check_eq("reset_rdata0", 64'(rd(0)), 64'd0);
    check_eq("reset_rdata1", 64'(rd(1)), 64'd0);

    // Port 1 write then read of addr 5; three miss cycles per access
    miss_hi[1] = 0;
    issue(1, 1'b1, 5, 32'hDEADBEEF); drain();
    check_eq("p1_wr_latency", 64'(miss_hi[1]), 64'(WS + 1));
    miss_hi[1] = 0;
    issue(1, 1'b0, 5, 0); drain();
    check_eq("p1_rd_latency", 64'(miss_hi[1]), 64'(WS + 1));
    check_eq("p1_rd5", 64'(rd(1)), 64'h0DEADBEEF);

    // Both ports requesting continuously: grants alternate, WS+2 cycles apart
    done_q.delete(); done_cyc.delete();
    rand_mode = 1'b1; req_pct = 100;
    repeat (16) cycle();
    rand_mode = 1'b0; drain();
    check_eq("rr_count", 64'(done_q.size() >= 4), 64'd1);
    if (done_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) check_eq("rr_order", 64'(done_q[k]), 64'(k % 2));
      for (int k = 0; k < 3; k++)
        check_eq("rr_spacing", 64'(done_cyc[k+1] - done_cyc[k]), 64'(WS + 2));
    end

    // Abort of a port 1 write to addr 7 during BUSY
    issue(1, 1'b1, 7, 32'h77777777); drain();
    issue(1, 1'b1, 7, 32'hBADBAD00); abort_req[1] = 1'b1; drain();
    done_q.delete(); done_cyc.delete();
    issue(0, 1'b0, 7, 0); issue(1, 1'b0, 7, 0); drain();
    check_eq("abort_next_grant", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd0);
    check_eq("abort_rd7_p0", 64'(rd(0)), 64'h77777777);
    check_eq("abort_rd7_p1", 64'(rd(1)), 64'h77777777);

    // Reset during BUSY of a write to addr 3
    issue(0, 1'b1, 3, 32'h33333333); drain();
    issue(0, 1'b1, 3, 32'hCAFEF00D);
    cycle(); cycle();
    rst_now = 1'b1; cycle(); rst_now = 1'b0;
    cycle();
    check_eq("midrst_rdata0", 64'(rd(0)), 64'd0);
    check_eq("midrst_rdata1", 64'(rd(1)), 64'd0);
    done_q.delete(); done_cyc.delete();
    issue(0, 1'b0, 3, 0); issue(1, 1'b0, 3, 0); drain();
    check_eq("midrst_first_grant", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd0);
    check_eq("midrst_rd3", 64'(rd(0)), 64'h33333333);

    // Write beyond the RAM depth
    issue(0, 1'b1, 0, 32'h0A0A0A0A); drain();
    err_hi[0] = 0;
    issue(0, 1'b1, 32'h400, 32'h12345678); drain();
    issue(0, 1'b0, 0, 0); drain();
    check_eq("oob_rd0", 64'(rd(0)), BoundsEn ? 64'h0A0A0A0A : 64'h12345678);
`ifdef UMC_BOUNDS_CHECK_EN
    check_eq("oob_err_pulses", 64'(err_hi[0]), 64'd1);
`endif

    // Random traffic with aborts and occasional resets
    rand_mode = 1'b1; rand_abort = 1'b1; req_pct = 35;
    for (int n = 0; n < 3000; n++) begin
      rst_now = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst_now = 1'b0; rand_mode = 1'b0; rand_abort = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
